// File: rtl/pwm_compare_dt.sv
`default_nettype none
// =============================================================================
// pwm_compare_dt : carrier comparator driving a complementary gate pair with
//                  dead-time insertion. Optional macro PWMCMP_SHADOW_EN.
// count_mode: 0 NO_COUNT, 1 COUNT_UP, 2 COUNT_DOWN, 3 COUNT_UPDOWN; pwm_onoff: 0 OFF, 1 ON
// Revision: 1.0
// =============================================================================
module pwm_compare_dt #(
  parameter int PWMCOUNT_WIDTH = 16,
  parameter int DT_WIDTH       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PWMCOUNT_WIDTH-1:0] carrier,
  input  logic [PWMCOUNT_WIDTH-1:0] period,
  input  logic [1:0]                count_mode,
  input  logic                      pwm_onoff,
  input  logic [PWMCOUNT_WIDTH-1:0] compare,
  input  logic [DT_WIDTH-1:0]       deadtime,
  output logic                      pwm_h,
  output logic                      pwm_l,
  output logic                      sync_event
);

  localparam logic [1:0]          NO_COUNT     = 2'd0;
  localparam logic [1:0]          COUNT_UPDOWN = 2'd3;
  localparam logic                PWM_OFF      = 1'b0;
  localparam logic [DT_WIDTH-1:0] DT_ONE       = {{(DT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_HIGH  = 3'd1,
    S_DT_HL = 3'd2,
    S_LOW   = 3'd3,
    S_DT_LH = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [DT_WIDTH-1:0]       cnt_q, cnt_d;
  logic [DT_WIDTH-1:0]       dt_sh_q, dt_sh_d;
  logic [PWMCOUNT_WIDTH-1:0] cmp_sh_q, cmp_sh_d;
  logic [PWMCOUNT_WIDTH-1:0] carrier_prev_q, carrier_prev_d;
  logic                      pwm_h_q, pwm_h_d;
  logic                      pwm_l_q, pwm_l_d;
  logic                      sync_event_q, sync_event_d;
  logic                      stop;
  logic                      event_hit;
  logic                      shadow_load;
  logic                      raw;

  always_comb begin
    stop      = (pwm_onoff == PWM_OFF) || (count_mode == NO_COUNT) || (period == '0);
    event_hit = ((carrier == '0) && (carrier_prev_q != '0)) ||
                ((count_mode == COUNT_UPDOWN) && (carrier == period) && (carrier_prev_q != period));
    raw       = (carrier < cmp_sh_q);
  end

`ifdef PWMCMP_SHADOW_EN
  // Shadows track the inputs freely while stopped so a restart uses fresh values.
  always_comb shadow_load = event_hit || stop;
`else
  always_comb shadow_load = 1'b1;
`endif

  always_comb begin
    carrier_prev_d = carrier;
    sync_event_d   = event_hit;
    cmp_sh_d       = shadow_load ? compare  : cmp_sh_q;
    dt_sh_d        = shadow_load ? deadtime : dt_sh_q;
  end

  // Any direction change restarts the dead time from the latest turn-off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (stop) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = raw ? S_DT_LH : S_DT_HL;
          cnt_d   = dt_sh_q;
        end
        S_HIGH: begin
          if (!raw) begin
            state_d = S_DT_HL;
            cnt_d   = dt_sh_q;
          end
        end
        S_LOW: begin
          if (raw) begin
            state_d = S_DT_LH;
            cnt_d   = dt_sh_q;
          end
        end
        S_DT_HL: begin
          if (raw) begin
            state_d = S_DT_LH;
            cnt_d   = dt_sh_q;
          end else if (cnt_q == '0) begin
            state_d = S_LOW;
          end else begin
            cnt_d = cnt_q - DT_ONE;
          end
        end
        S_DT_LH: begin
          if (!raw) begin
            state_d = S_DT_HL;
            cnt_d   = dt_sh_q;
          end else if (cnt_q == '0) begin
            state_d = S_HIGH;
          end else begin
            cnt_d = cnt_q - DT_ONE;
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end
    pwm_h_d = (state_d == S_HIGH);
    pwm_l_d = (state_d == S_LOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_OFF;
      cnt_q          <= '0;
      dt_sh_q        <= '0;
      cmp_sh_q       <= '0;
      carrier_prev_q <= '0;
      pwm_h_q        <= 1'b0;
      pwm_l_q        <= 1'b0;
      sync_event_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dt_sh_q        <= dt_sh_d;
      cmp_sh_q       <= cmp_sh_d;
      carrier_prev_q <= carrier_prev_d;
      pwm_h_q        <= pwm_h_d;
      pwm_l_q        <= pwm_l_d;
      sync_event_q   <= sync_event_d;
    end
  end

  assign pwm_h      = pwm_h_q;
  assign pwm_l      = pwm_l_q;
  assign sync_event = sync_event_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_compare_dt.sv
`default_nettype none
// =============================================================================
// tb_pwm_compare_dt : directed bench for pwm_compare_dt edge timing, shadowing,
//                     dead-time glitches, saturation, stop/resume and reset.
// Revision: 1.0
// =============================================================================
module tb_pwm_compare_dt;

  localparam int         W            = 16;
  localparam int         DTW          = 8;
  localparam logic [1:0] NO_COUNT     = 2'd0;
  localparam logic [1:0] COUNT_UP     = 2'd1;
  localparam logic [1:0] COUNT_UPDOWN = 2'd3;
  localparam logic       PWM_OFF      = 1'b0;
  localparam logic       PWM_ON       = 1'b1;
`ifdef PWMCMP_SHADOW_EN
  localparam int         SHADOW       = 1;
`else
  localparam int         SHADOW       = 0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   carrier, period, compare;
  logic [1:0]     count_mode;
  logic           pwm_onoff;
  logic [DTW-1:0] deadtime;
  logic           pwm_h, pwm_l, sync_event;

  int   n_vec = 0;
  int   n_err = 0;
  int   overlap = 0;
  int   car;
  bit   dir_up;
  logic h_log [0:255];
  logic l_log [0:255];
  logic s_log [0:255];

  always #5 clk = ~clk;

  pwm_compare_dt #(.PWMCOUNT_WIDTH(W), .DT_WIDTH(DTW)) dut (
    .clk        (clk),
    .reset      (reset),
    .carrier    (carrier),
    .period     (period),
    .count_mode (count_mode),
    .pwm_onoff  (pwm_onoff),
    .compare    (compare),
    .deadtime   (deadtime),
    .pwm_h      (pwm_h),
    .pwm_l      (pwm_l),
    .sync_event (sync_event)
  );

  task automatic check_vec(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (pwm_h && pwm_l) overlap++;
  endtask

  task automatic stop_setup(input logic [1:0] mode, input int per, input int cmp,
                            input int dt, input int c0);
    pwm_onoff  = PWM_OFF;
    count_mode = mode;
    period     = per[W-1:0];
    compare    = cmp[W-1:0];
    deadtime   = dt[DTW-1:0];
    car        = c0;
    dir_up     = 1'b1;
    carrier    = car[W-1:0];
    repeat (3) cyc();
  endtask

  // gen: 0 hold, 1 up saw, 2 up/down triangle, 3 hold at 5 with a two-cycle dip to 60
  task automatic run_log(input int n, input int gen, input int chg_k, input int chg_cmp);
    for (int k = 0; k < n; k++) begin
      if (k == chg_k) compare = chg_cmp[W-1:0];
      if (gen == 3) car = (k == 15 || k == 16) ? 60 : 5;
      carrier = car[W-1:0];
      cyc();
      h_log[k] = pwm_h;
      l_log[k] = pwm_l;
      s_log[k] = sync_event;
      if (gen == 1) begin
        car = (car >= int'(period)) ? 0 : car + 1;
      end else if (gen == 2) begin
        if (dir_up) begin
          if (car == int'(period)) begin dir_up = 1'b0; car = car - 1; end
          else car = car + 1;
        end else begin
          if (car == 0) begin dir_up = 1'b1; car = 1; end
          else car = car - 1;
        end
      end
    end
  endtask

  function automatic logic log_bit(input int sel, input int k);
    if (sel == 0) return h_log[k];
    if (sel == 1) return l_log[k];
    return s_log[k];
  endfunction

  function automatic int find(input int sel, input logic v, input int from, input int to);
    for (int k = from; k <= to; k++) if (log_bit(sel, k) == v) return k;
    return -1;
  endfunction

  function automatic int count1(input int sel, input int from, input int to);
    int c = 0;
    for (int k = from; k <= to; k++) if (log_bit(sel, k) == 1'b1) c++;
    return c;
  endfunction

  initial begin
    reset      = 1'b1;
    pwm_onoff  = PWM_OFF;
    count_mode = NO_COUNT;
    period     = '0;
    compare    = '0;
    deadtime   = '0;
    carrier    = '0;
    car        = 0;
    dir_up     = 1'b1;
    repeat (2) cyc();
    check_vec("rst_h", pwm_h, 0);
    check_vec("rst_l", pwm_l, 0);
    check_vec("rst_sync", sync_event, 0);
    reset = 1'b0;

    // COUNT_UP edge timing
    stop_setup(COUNT_UP, 100, 40, 5, 0);
    pwm_onoff = PWM_ON;
    run_log(121, 1, -1, 0);
    check_vec("up_h_rise0", find(0, 1'b1, 0, 120), 6);
    check_vec("up_h_fall", find(0, 1'b0, 6, 120), 40);
    check_vec("up_l_rise", find(1, 1'b1, 0, 120), 46);
    check_vec("up_l_fall", find(1, 1'b0, 46, 120), 101);
    check_vec("up_h_rise1", find(0, 1'b1, 41, 120), 107);
    check_vec("up_sync_pos", find(2, 1'b1, 0, 120), 101);
    check_vec("up_sync_cnt", count1(2, 0, 120), 1);

    // COUNT_UPDOWN shadow load, compare 20 -> 30 on the down slope
    stop_setup(COUNT_UPDOWN, 50, 20, 2, 0);
    pwm_onoff = PWM_ON;
    run_log(161, 2, 60, 30);
    check_vec("ud_h_rise0", find(0, 1'b1, 0, 160), 3);
    check_vec("ud_h_fall0", find(0, 1'b0, 3, 160), 20);
    check_vec("ud_sync_peak", find(2, 1'b1, 0, 160), 50);
    check_vec("ud_sync_valley", find(2, 1'b1, 51, 160), 100);
    check_vec("ud_sync_cnt", count1(2, 0, 160), 3);
    check_vec("ud_h_rise_chg", find(0, 1'b1, 60, 160), (SHADOW != 0) ? 84 : 74);
    check_vec("ud_h_fall_new", find(0, 1'b0, 100, 160), 130);

    // raw glitch 1->0->1 inside a 10-cycle dead time
    stop_setup(COUNT_UP, 100, 40, 10, 5);
    pwm_onoff = PWM_ON;
    run_log(41, 3, -1, 0);
    check_vec("gl_h_rise0", find(0, 1'b1, 0, 40), 11);
    check_vec("gl_h_fall", find(0, 1'b0, 11, 40), 15);
    check_vec("gl_h_rise1", find(0, 1'b1, 16, 40), 28);
    check_vec("gl_l_never", count1(1, 0, 40), 0);

    // saturated compare values
    stop_setup(COUNT_UP, 100, 0, 3, 0);
    pwm_onoff = PWM_ON;
    run_log(121, 1, -1, 0);
    check_vec("c0_l_rise", find(1, 1'b1, 0, 120), 4);
    check_vec("c0_l_hold", count1(1, 4, 120), 117);
    check_vec("c0_h_never", count1(0, 0, 120), 0);
    stop_setup(COUNT_UP, 100, 101, 3, 0);
    pwm_onoff = PWM_ON;
    run_log(121, 1, -1, 0);
    check_vec("cmax_h_rise", find(0, 1'b1, 0, 120), 4);
    check_vec("cmax_h_hold", count1(0, 4, 120), 117);
    check_vec("cmax_l_never", count1(1, 0, 120), 0);

    // stop while high, then resume with a new dead time
    pwm_onoff = PWM_OFF;
    cyc();
    check_vec("stop_h", pwm_h, 0);
    check_vec("stop_l", pwm_l, 0);
    deadtime = 8'd4;
    repeat (2) cyc();
    pwm_onoff = PWM_ON;
    run_log(20, 1, -1, 0);
    check_vec("resume_h_rise", find(0, 1'b1, 0, 19), 5);
    check_vec("resume_l_never", count1(1, 0, 19), 0);

    // reset in S_DT_LH with the counter at 4, period forced to 0
    stop_setup(COUNT_UP, 100, 101, 10, 5);
    pwm_onoff = PWM_ON;
    run_log(7, 0, -1, 0);
    check_vec("pre_rst_h", h_log[6], 0);
    reset  = 1'b1;
    period = '0;
    cyc();
    check_vec("mid_rst_h", pwm_h, 0);
    check_vec("mid_rst_l", pwm_l, 0);
    check_vec("mid_rst_sync", sync_event, 0);
    reset = 1'b0;
    run_log(20, 0, -1, 0);
    check_vec("p0_h_never", count1(0, 0, 19), 0);
    check_vec("p0_l_never", count1(1, 0, 19), 0);

    // reset while running: shadows return to 0
    period = 16'd100;
    run_log(20, 0, -1, 0);
    check_vec("run_h_rise", find(0, 1'b1, 0, 19), 11);
    reset = 1'b1;
    cyc();
    check_vec("run_rst_h", pwm_h, 0);
    reset = 1'b0;
    run_log(30, 0, -1, 0);
    if (SHADOW != 0) begin
      check_vec("post_rst_l_rise", find(1, 1'b1, 0, 29), 1);
      check_vec("post_rst_h_never", count1(0, 0, 29), 0);
    end else begin
      check_vec("post_rst_h_rise", find(0, 1'b1, 0, 29), 12);
      check_vec("post_rst_l_never", count1(1, 0, 29), 0);
    end

    check_vec("no_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
